mem_load_unit: RTL and testbench
================================

// Module: mem_load_unit
// PURPOSE
//  Load-return stage directly downstream of the data memory (DM) in the MEM stage.
//  DM is a synchronous-read block RAM, so read data (douta) becomes valid one cycle after the address.
//  This block latches the load attributes and selects DM or device read data.
//  It aligns and sign/zero-extends the data, then holds the result in a valid/ready handshake to the W stage.
// PARAMETERS
//  DM_TOP    32'h0000_1fff  last byte address served by DM (DM region is 0..DM_TOP)
//  DEV_BASE  32'h0000_7f00  first byte address of the device window (bridge)
//  DEV_TOP   32'h0000_7f1f  last byte address of the device window
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  ld_req       in   1   MEM stage presents a load this cycle
//  ld_ready     out  1   block accepts the load (transfer = ld_req & ld_ready)
//  ADDR         in   32  load byte address (same value driven to DM/bridge this cycle)
//  byte_op      in   1   byte load (lb/lbu)
//  half_op      in   1   halfword load (lh/lhu); word load if neither is set
//  ld_unsigned  in   1   zero-extend (lbu/lhu); sign-extend otherwise
//  dst_reg      in   5   destination GPR
//  WPC          in   32  PC of the load instruction
//  dm_rd        in   32  DM douta, valid the cycle after the address
//  dev_rd       in   32  bridge read data, valid the cycle after the address
//  wb_valid     out  1   result held for the W stage
//  wb_ready     in   1   W stage consumes the result
//  wb_data      out  32  extended load data
//  wb_reg       out  5   destination GPR
//  wb_pc        out  32  PC of the load
//  adel         out  1   address-error-on-load flag for this result
// BEHAVIOUR
//  - States: IDLE, WAIT, HOLD.
//    - IDLE: ld_ready=1. On a transfer, latch ADDR[1:0], the op bits, ld_unsigned, dst_reg and WPC; go to WAIT.
//    - WAIT: ld_ready=0. At the next edge, capture the selected read data, extend it into wb_data, and go to HOLD.
//    - HOLD: wb_valid=1; ld_ready=wb_ready.
//      - wb_ready without ld_req -> IDLE.
//      - wb_ready with ld_req -> accept the new load and go to WAIT (back-to-back throughput: one load per 2 cycles).
//      - !wb_ready -> stay; all wb_* outputs stay stable while wb_valid=1.
//  - Latency: load accepted at edge T; wb_valid=1 from edge T+2 until the consuming edge.
//  - Source select is latched at accept:
//    - ADDR<=DM_TOP -> dm_rd.
//    - DEV_BASE<=ADDR<=DEV_TOP -> dev_rd.
//    - Otherwise -> adel=1.
//  - Alignment: misaligned when half_op & ADDR[0], or word & ADDR[1:0]!=0.
//    A misaligned load gives adel=1 and wb_data=0. It still follows IDLE->WAIT->HOLD, so exceptions stay in program order.
//  - Lane extraction (byte_addr = latched ADDR[1:0]):
//    - byte: rd[8*byte_addr +: 8].
//    - half: rd[15:0] if byte_addr=0, rd[31:16] if byte_addr=2.
//    - word: rd.
//    - Sign/zero extension to 32 bits per ld_unsigned; ignored for word loads.
//  - byte_op and half_op both set: treated as byte.
//  - ld_req while ld_ready=0 is ignored; the MEM stage stalls on ld_ready.
//  - Reset (any state, including WAIT/HOLD mid-load):
//    - Next state IDLE; in-flight load dropped.
//    - wb_valid=0, wb_data=0, wb_reg=0, wb_pc=0, adel=0; ld_ready=1 after reset.
//  - Only registered values drive outputs; dm_rd/dev_rd changes in HOLD must not affect wb_data.
// TESTING
//  - lb at ADDR=0x0000_0003, dm_rd=0x80AB_CDEF at T+1 -> at T+2 wb_valid=1, wb_data=0xFFFF_FF80; lbu -> 0x0000_0080.
//  - lh at 0x0000_0102, dm_rd=0x7FFE_1234 -> wb_data=0x0000_7FFE.
//    lw at 0x0000_0100 -> wb_data=0x7FFE_1234, wb_reg/wb_pc equal the values driven at accept.
//  - HOLD with wb_ready=0 for 5 cycles while dm_rd toggles -> wb_* constant, ld_ready=0.
//    Then wb_ready=1 with ld_req=1 -> new load accepted that same edge, next wb_valid 2 edges later.
//  - lw at 0x0000_0102 -> adel=1, wb_data=0. lw at 0x0000_7f04, dev_rd=0x1234_5678 -> adel=0, wb_data=0x1234_5678.
//    lw at 0x0000_4000 -> adel=1.
//  - reset=1 in WAIT and again in HOLD -> next cycle wb_valid=0, all wb_* zero, ld_ready=1, no stale result afterwards.
//  - Random back-to-back loads with random wb_ready vs. reference model -> every accepted load returned exactly once, in order.

Source files
------------

// File: rtl/mem_load_unit.sv
// Load-return stage behind the synchronous-read data memory: latches load attributes,
// selects DM or device data, aligns/extends it and holds it for the W stage.
module mem_load_unit #(
    parameter logic [31:0] DM_TOP   = 32'h0000_1fff,
    parameter logic [31:0] DEV_BASE = 32'h0000_7f00,
    parameter logic [31:0] DEV_TOP  = 32'h0000_7f1f
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    output logic        ld_ready,
    input  logic [31:0] ADDR,
    input  logic        byte_op,
    input  logic        half_op,
    input  logic        ld_unsigned,
    input  logic [4:0]  dst_reg,
    input  logic [31:0] WPC,
    input  logic [31:0] dm_rd,
    input  logic [31:0] dev_rd,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_pc,
    output logic        adel
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    state_t state;

    logic [1:0]  addr_lo_q;
    logic        byte_q, half_q, uns_q, dev_q, err_q;
    logic [4:0]  reg_q;
    logic [31:0] pc_q;

    logic        accept, in_dm, in_dev, misaligned;
    logic [31:0] rd, shifted, ext;

    assign ld_ready = (state == IDLE) || ((state == HOLD) && wb_ready);
    assign accept   = ld_req && ld_ready;

    // byte_op wins when both op bits are set, so a byte load is never misaligned
    always_comb begin
        in_dm      = (ADDR <= DM_TOP);
        in_dev     = (ADDR >= DEV_BASE) && (ADDR <= DEV_TOP);
        misaligned = 1'b0;
        if (!byte_op) begin
            if (half_op) misaligned = ADDR[0];
            else         misaligned = (ADDR[1:0] != 2'b00);
        end
    end

    // Aligned halves/words have addr_lo_q of 0 or 2, so one shifter serves every width
    always_comb begin
        rd      = dev_q ? dev_rd : dm_rd;
        shifted = rd >> {addr_lo_q, 3'b000};
        if (byte_q)      ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
        else if (half_q) ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
        else             ext = shifted;
        if (err_q) ext = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_reg    <= '0;
            wb_pc     <= '0;
            adel      <= 1'b0;
            addr_lo_q <= '0;
            byte_q    <= 1'b0;
            half_q    <= 1'b0;
            uns_q     <= 1'b0;
            dev_q     <= 1'b0;
            err_q     <= 1'b0;
            reg_q     <= '0;
            pc_q      <= '0;
        end else begin
            if (accept) begin
                addr_lo_q <= ADDR[1:0];
                byte_q    <= byte_op;
                half_q    <= half_op & ~byte_op;
                uns_q     <= ld_unsigned;
                dev_q     <= ~in_dm & in_dev;
                err_q     <= ~(in_dm | in_dev) | misaligned;
                reg_q     <= dst_reg;
                pc_q      <= WPC;
            end
            case (state)
                IDLE: if (ld_req) state <= WAIT;
                WAIT: begin
                    wb_data  <= ext;
                    wb_reg   <= reg_q;
                    wb_pc    <= pc_q;
                    adel     <= err_q;
                    wb_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: if (wb_ready) begin
                    wb_valid <= 1'b0;
                    state    <= ld_req ? WAIT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: extension/alignment vectors, stalls, region checks,
// reset mid-load and a short back-to-back run against a reference model.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset, ld_req, ld_ready, byte_op, half_op, ld_unsigned;
    logic        wb_valid, wb_ready, adel;
    logic [31:0] ADDR, WPC, dm_rd, dev_rd, wb_data, wb_pc;
    logic [4:0]  dst_reg, wb_reg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_load_unit #(.DM_TOP(32'h0000_1fff), .DEV_BASE(32'h0000_7f00), .DEV_TOP(32'h0000_7f1f)) dut (
        .clk(clk), .reset(reset), .ld_req(ld_req), .ld_ready(ld_ready), .ADDR(ADDR),
        .byte_op(byte_op), .half_op(half_op), .ld_unsigned(ld_unsigned), .dst_reg(dst_reg),
        .WPC(WPC), .dm_rd(dm_rd), .dev_rd(dev_rd), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_pc(wb_pc), .adel(adel)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a load in IDLE, then supply read data during WAIT; returns in HOLD
    task automatic run_load(input logic [31:0] a, input logic b, input logic h, input logic u,
                            input logic [4:0] r, input logic [31:0] pc,
                            input logic [31:0] dm, input logic [31:0] dev);
        ADDR = a; byte_op = b; half_op = h; ld_unsigned = u; dst_reg = r; WPC = pc;
        ld_req = 1'b1;
        step();
        ld_req = 1'b0;
        chk("wait_ld_ready", {31'd0, ld_ready}, 32'd0);
        dm_rd = dm; dev_rd = dev;
        step();
    endtask

    task automatic consume();
        wb_ready = 1'b1;
        #1;
        chk("hold_ld_ready", {31'd0, ld_ready}, 32'd1);
        step();
        wb_ready = 1'b0;
        chk("after_consume_valid", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_data"}, wb_data, 32'd0);
        chk({tag, "_reg"}, {27'd0, wb_reg}, 32'd0);
        chk({tag, "_pc"}, wb_pc, 32'd0);
        chk({tag, "_adel"}, {31'd0, adel}, 32'd0);
        chk({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd1);
    endtask

    function automatic logic model_adel(input logic [31:0] a, input logic b, input logic h);
        logic in_range, mis;
        in_range = (a <= 32'h1fff) || (a >= 32'h7f00 && a <= 32'h7f1f);
        if (b)      mis = 1'b0;
        else if (h) mis = a[0];
        else        mis = (a[1:0] != 2'b00);
        return !in_range || mis;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] a, input logic b, input logic h,
                                               input logic u, input logic [31:0] rd);
        logic [31:0] v;
        logic [1:0]  lane;
        lane = a[1:0];
        if (model_adel(a, b, h)) return 32'd0;
        if (b) begin
            case (lane)
                2'd0: v = {24'd0, rd[7:0]};
                2'd1: v = {24'd0, rd[15:8]};
                2'd2: v = {24'd0, rd[23:16]};
                default: v = {24'd0, rd[31:24]};
            endcase
            if (!u && v[7]) v = v | 32'hffff_ff00;
        end else if (h) begin
            v = lane[1] ? {16'd0, rd[31:16]} : {16'd0, rd[15:0]};
            if (!u && v[15]) v = v | 32'hffff_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    logic [31:0] ra, rpc, rdm, rdev, e_data, e_pc;
    logic        rb, rh, ru, e_adel, have_prev;
    logic [4:0]  rr, e_reg;
    int unsigned stalls;

    initial begin
        reset = 1'b1; ld_req = 1'b0; wb_ready = 1'b0; ADDR = '0; byte_op = 1'b0; half_op = 1'b0;
        ld_unsigned = 1'b0; dst_reg = '0; WPC = '0; dm_rd = '0; dev_rd = '0;
        step(); step();
        reset = 1'b0;
        chk_zero("reset");

        // lb / lbu on the top lane
        run_load(32'h0000_0003, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0400, 32'h80AB_CDEF, 32'h0);
        chk("lb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_adel", {31'd0, adel}, 32'd0);
        chk("lb_ld_ready_stall", {31'd0, ld_ready}, 32'd0);
        consume();
        run_load(32'h0000_0003, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0404, 32'h80AB_CDEF, 32'h0);
        chk("lbu_data", wb_data, 32'h0000_0080);
        consume();

        run_load(32'h0000_0102, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_0408, 32'h7FFE_1234, 32'h0);
        chk("lh_data", wb_data, 32'h0000_7FFE);
        consume();
        run_load(32'h0000_0100, 1'b0, 1'b0, 1'b0, 5'd17, 32'h0000_040C, 32'h7FFE_1234, 32'h0);
        chk("lw_data", wb_data, 32'h7FFE_1234);
        chk("lw_reg", {27'd0, wb_reg}, 32'd17);
        chk("lw_pc", wb_pc, 32'h0000_040C);

        // Stall in HOLD while read data keeps changing
        for (int i = 0; i < 5; i++) begin
            dm_rd = ~dm_rd; dev_rd = dev_rd + 32'h1111_1111;
            step();
            chk("stall_data", wb_data, 32'h7FFE_1234);
            chk("stall_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_ld_ready", {31'd0, ld_ready}, 32'd0);
        end
        chk("stall_reg", {27'd0, wb_reg}, 32'd17);
        chk("stall_pc", wb_pc, 32'h0000_040C);

        // Consume and accept the next load (lhu, device, upper half) on the same edge
        ADDR = 32'h0000_7f02; byte_op = 1'b0; half_op = 1'b1; ld_unsigned = 1'b1;
        dst_reg = 5'd9; WPC = 32'h0000_0410; ld_req = 1'b1; wb_ready = 1'b1;
        #1;
        chk("b2b_ld_ready", {31'd0, ld_ready}, 32'd1);
        step();
        ld_req = 1'b0; wb_ready = 1'b0;
        chk("b2b_wait_valid", {31'd0, wb_valid}, 32'd0);
        chk("b2b_wait_ld_ready", {31'd0, ld_ready}, 32'd0);
        dev_rd = 32'h8001_ABCD;
        step();
        chk("b2b_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_data", wb_data, 32'h0000_8001);
        chk("b2b_reg", {27'd0, wb_reg}, 32'd9);
        consume();

        // Regions, alignment and window boundaries
        run_load(32'h0000_0102, 1'b0, 1'b0, 1'b0, 5'd1, 32'h500, 32'hDEAD_BEEF, 32'h0);
        chk("mis_lw_adel", {31'd0, adel}, 32'd1);
        chk("mis_lw_data", wb_data, 32'd0);
        consume();
        run_load(32'h0000_7f04, 1'b0, 1'b0, 1'b0, 5'd2, 32'h504, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("dev_lw_adel", {31'd0, adel}, 32'd0);
        chk("dev_lw_data", wb_data, 32'h1234_5678);
        consume();
        run_load(32'h0000_4000, 1'b0, 1'b0, 1'b0, 5'd3, 32'h508, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("gap_lw_adel", {31'd0, adel}, 32'd1);
        consume();
        run_load(32'h0000_1fff, 1'b1, 1'b0, 1'b0, 5'd4, 32'h50C, 32'h7F00_0000, 32'h0);
        chk("dm_top_adel", {31'd0, adel}, 32'd0);
        chk("dm_top_data", wb_data, 32'h0000_007F);
        consume();
        run_load(32'h0000_2000, 1'b0, 1'b0, 1'b0, 5'd5, 32'h510, 32'h1, 32'h2);
        chk("dm_top_plus1_adel", {31'd0, adel}, 32'd1);
        consume();
        run_load(32'h0000_7f1f, 1'b1, 1'b0, 1'b1, 5'd6, 32'h514, 32'h0, 32'hA500_0000);
        chk("dev_top_adel", {31'd0, adel}, 32'd0);
        chk("dev_top_data", wb_data, 32'h0000_00A5);
        consume();
        run_load(32'h0000_7f20, 1'b1, 1'b0, 1'b0, 5'd7, 32'h518, 32'h0, 32'hA500_0000);
        chk("dev_top_plus1_adel", {31'd0, adel}, 32'd1);
        consume();
        run_load(32'h0000_0001, 1'b1, 1'b1, 1'b0, 5'd8, 32'h51C, 32'h0000_8000, 32'h0);
        chk("byte_half_adel", {31'd0, adel}, 32'd0);
        chk("byte_half_data", wb_data, 32'hFFFF_FF80);
        consume();
        run_load(32'h0000_0003, 1'b0, 1'b1, 1'b0, 5'd8, 32'h520, 32'h0, 32'h0);
        chk("mis_lh_adel", {31'd0, adel}, 32'd1);
        consume();

        // Reset during WAIT
        ADDR = 32'h0000_0010; byte_op = 1'b0; half_op = 1'b0; dst_reg = 5'd21; WPC = 32'h600;
        ld_req = 1'b1;
        step();
        ld_req = 1'b0; dm_rd = 32'hCAFE_F00D; reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("rst_wait");
        step(); step();
        chk("rst_wait_no_stale", {31'd0, wb_valid}, 32'd0);

        // Reset during HOLD
        run_load(32'h0000_0010, 1'b0, 1'b0, 1'b0, 5'd22, 32'h604, 32'hCAFE_F00D, 32'h0);
        chk("pre_rst_hold_valid", {31'd0, wb_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero("rst_hold");
        step(); step();
        chk("rst_hold_no_stale", {31'd0, wb_valid}, 32'd0);

        // Back-to-back loads with random stalls against the model
        have_prev = 1'b0;
        e_data = '0; e_reg = '0; e_pc = '0; e_adel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom_range(0, 32'h1fff);
                1:       ra = 32'h7f00 + $urandom_range(0, 31);
                2:       ra = 32'h2000 + $urandom_range(0, 32'h5eff);
                default: ra = ($urandom_range(0, 1) == 0) ? 32'h1ffc : 32'h7f1c;
            endcase
            rb = 1'($urandom_range(0, 1)); rh = 1'($urandom_range(0, 1)); ru = 1'($urandom_range(0, 1));
            rr = 5'($urandom_range(0, 31)); rpc = $urandom;
            rdm = $urandom; rdev = $urandom;
            if (have_prev) begin
                wb_ready = 1'b1;
                #1;
                chk("rnd_valid", {31'd0, wb_valid}, 32'd1);
                chk("rnd_data", wb_data, e_data);
                chk("rnd_reg", {27'd0, wb_reg}, {27'd0, e_reg});
                chk("rnd_pc", wb_pc, e_pc);
                chk("rnd_adel", {31'd0, adel}, {31'd0, e_adel});
            end
            chk("rnd_ld_ready", {31'd0, ld_ready}, 32'd1);
            ADDR = ra; byte_op = rb; half_op = rh; ld_unsigned = ru; dst_reg = rr; WPC = rpc;
            ld_req = 1'b1;
            step();
            ld_req = 1'b0; wb_ready = 1'b0;
            dm_rd = rdm; dev_rd = rdev;
            e_adel = model_adel(ra, rb, rh);
            e_data = model_data(ra, rb, rh, ru, (ra <= 32'h1fff) ? rdm : rdev);
            e_reg = rr; e_pc = rpc;
            step();
            stalls = $urandom_range(0, 2);
            for (int s = 0; s < int'(stalls); s++) begin
                dm_rd = $urandom; dev_rd = $urandom;
                step();
                chk("rnd_stall_data", wb_data, e_data);
            end
            have_prev = 1'b1;
        end
        chk("rnd_last_data", wb_data, e_data);
        chk("rnd_last_reg", {27'd0, wb_reg}, {27'd0, e_reg});
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
